usb_rx_seq: RTL and testbench

//  Receive-side sequencer in front of the bit unstuffer.

---
 rtl/usb_rx_seq.sv | 229 ++++++++++++++++++++++
 tb/tb_usb_rx_seq.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_seq.sv
// ---------------------------------------------------------------------------
// usb_rx_seq
//   Receive-side sequencer in front of the bit unstuffer. Takes the NRZI
//   decoded line stream one bit per clock, hunts for the SYNC pattern, then
//   gates packet and EOP bits into the unstuffer. Flags bit-stuff, EOP and
//   length errors at packet end, and a timeout when SYNC never shows up.
//
// Ports
//   clk             system clock, one line bit per cycle
//   rst_b           asynchronous active-low reset
//   rx_en           level: a packet is expected
//   line_bit        NRZI-decoded bit (ignored while line_se0=1)
//   line_se0        line is in SE0 this cycle
//   bstr_out        bit to the unstuffer
//   bstr_out_avail  bstr_out valid (packet and EOP bits, never SYNC)
//   out_done        1-cycle pulse when a packet ends (good or error)
//   rx_busy         high from SYNC match through EOP
//   rx_err          1-cycle pulse coincident with out_done on error
//   err_code        01 stuff, 10 bad EOP, 11 overflow; held until next error
//   rx_timeout      1-cycle pulse after TIMEOUT_CYC cycles in HUNT
//
// Every output is a flop: the line sample taken in cycle N is reflected on
// the outputs in cycle N+1.
// ---------------------------------------------------------------------------
module usb_rx_seq #(
  parameter int SYNC_MIN_ZEROS = 5,
  parameter int MAX_BITS       = 1100,
  parameter int TIMEOUT_CYC    = 255
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       rx_en,
  input  logic       line_bit,
  input  logic       line_se0,
  output logic       bstr_out,
  output logic       bstr_out_avail,
  output logic       out_done,
  output logic       rx_busy,
  output logic       rx_err,
  output logic [1:0] err_code,
  output logic       rx_timeout
);

  localparam int BIT_W = $clog2(MAX_BITS + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [BIT_W-1:0] BIT_MAX  = BIT_W'(MAX_BITS);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYC);
  localparam logic [2:0]       ZERO_MIN = 3'(SYNC_MIN_ZEROS);

  // Six consecutive ones are legal (the seventh must have been stuffed).
  localparam logic [2:0] ONES_LIMIT = 3'd6;

  localparam logic [1:0] ERR_STUFF = 2'b01;
  localparam logic [1:0] ERR_EOP   = 2'b10;
  localparam logic [1:0] ERR_OVFL  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HUNT,
    S_DATA,
    S_EOP1,
    S_EOP2,
    S_DONE,
    S_ERR
  } state_t;

  state_t state, state_nxt;

  logic [2:0]       zero_cnt, zero_nxt;
  logic [2:0]       ones_run, ones_nxt;
  logic [BIT_W-1:0] bit_cnt,  bit_nxt;
  logic [TO_W-1:0]  to_cnt,   to_nxt;

  logic             bstr_nxt;
  logic             avail_nxt;
  logic             done_nxt;
  logic             busy_nxt;
  logic             err_nxt;
  logic [1:0]       code_nxt;
  logic             timeout_nxt;

  logic [TO_W-1:0]  to_inc;
  logic [BIT_W-1:0] bit_inc;

  // Saturating increment for the SYNC zero counter: a long idle-zero stretch
  // must not wrap back below the SYNC threshold.
  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

  assign to_inc  = to_cnt + TO_W'(1);
  assign bit_inc = bit_cnt + BIT_W'(1);

  // ---- next-state / next-output decode ----
  always_comb begin
    state_nxt   = state;
    zero_nxt    = zero_cnt;
    ones_nxt    = ones_run;
    bit_nxt     = bit_cnt;
    to_nxt      = to_cnt;
    bstr_nxt    = 1'b0;
    avail_nxt   = 1'b0;
    code_nxt    = err_code;
    timeout_nxt = 1'b0;

    if (state != S_IDLE && !rx_en) begin
      // Abort has priority over any error, DONE or timeout in the same cycle.
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (rx_en) begin
            state_nxt = S_HUNT;
            zero_nxt  = 3'd0;
            to_nxt    = '0;
          end
        end

        S_HUNT: begin
          to_nxt = to_inc;
          if (line_se0) begin
            zero_nxt = 3'd0;
          end else if (!line_bit) begin
            zero_nxt = sat_inc3(zero_cnt);
          end else if (zero_cnt >= ZERO_MIN) begin
            // SYNC-terminating 1: consumed here, never forwarded.
            state_nxt = S_DATA;
            ones_nxt  = 3'd0;
            bit_nxt   = '0;
          end else begin
            zero_nxt = 3'd0;
          end
          // A SYNC completing on the last allowed cycle still wins.
          if (state_nxt == S_HUNT && to_inc == TO_MAX) begin
            state_nxt   = S_IDLE;
            timeout_nxt = 1'b1;
          end
        end

        S_DATA: begin
          if (line_se0) begin
            state_nxt = S_EOP1;
            avail_nxt = 1'b1;
          end else if (line_bit && ones_run == ONES_LIMIT) begin
            state_nxt = S_ERR;
            code_nxt  = ERR_STUFF;
          end else if (bit_cnt == BIT_MAX) begin
            state_nxt = S_ERR;
            code_nxt  = ERR_OVFL;
          end else begin
            bstr_nxt  = line_bit;
            avail_nxt = 1'b1;
            bit_nxt   = bit_inc;
            ones_nxt  = line_bit ? ones_run + 3'd1 : 3'd0;
          end
        end

        S_EOP1: begin
          if (line_se0) begin
            state_nxt = S_EOP2;
            avail_nxt = 1'b1;
          end else begin
            state_nxt = S_ERR;
            code_nxt  = ERR_EOP;
          end
        end

        S_EOP2: begin
          if (line_se0) begin
            state_nxt = S_ERR;
            code_nxt  = ERR_EOP;
          end else begin
            state_nxt = S_DONE;
          end
        end

        S_DONE:  state_nxt = S_IDLE;
        S_ERR:   state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end

    // Status outputs follow the state being entered so they line up with it.
    done_nxt = (state_nxt == S_DONE) || (state_nxt == S_ERR);
    err_nxt  = (state_nxt == S_ERR);
    busy_nxt = (state_nxt == S_DATA) || (state_nxt == S_EOP1) ||
               (state_nxt == S_EOP2);
  end

  // ---- state and counter registers ----
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state    <= S_IDLE;
      zero_cnt <= 3'd0;
      ones_run <= 3'd0;
      bit_cnt  <= '0;
      to_cnt   <= '0;
    end else begin
      state    <= state_nxt;
      zero_cnt <= zero_nxt;
      ones_run <= ones_nxt;
      bit_cnt  <= bit_nxt;
      to_cnt   <= to_nxt;
    end
  end

  // ---- output registers ----
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      bstr_out       <= 1'b0;
      bstr_out_avail <= 1'b0;
      out_done       <= 1'b0;
      rx_busy        <= 1'b0;
      rx_err         <= 1'b0;
      err_code       <= 2'b00;
      rx_timeout     <= 1'b0;
    end else begin
      bstr_out       <= bstr_nxt;
      bstr_out_avail <= avail_nxt;
      out_done       <= done_nxt;
      rx_busy        <= busy_nxt;
      rx_err         <= err_nxt;
      err_code       <= code_nxt;
      rx_timeout     <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_usb_rx_seq.sv
// ---------------------------------------------------------------------------
// tb_usb_rx_seq
//   Scenario bench for usb_rx_seq. Each step drives one line cycle, pushes
//   the outputs expected one cycle later, and captures what the DUT shows.
//   Each scenario task then drains both queues and compares them.
//   Observed vector: {bstr_out, avail, out_done, rx_busy, rx_err,
//   err_code[1:0], rx_timeout}; bstr_out is only compared while avail=1.
// ---------------------------------------------------------------------------
module tb_usb_rx_seq;

  localparam int SYNC_MIN_ZEROS = 5;
  localparam int MAX_BITS       = 40;
  localparam int TIMEOUT_CYC    = 16;

  logic       clk = 1'b0;
  logic       rst_b;
  logic       rx_en;
  logic       line_bit;
  logic       line_se0;
  logic       bstr_out;
  logic       bstr_out_avail;
  logic       out_done;
  logic       rx_busy;
  logic       rx_err;
  logic [1:0] err_code;
  logic       rx_timeout;

  logic [7:0] obs;
  assign obs = {bstr_out, bstr_out_avail, out_done, rx_busy, rx_err, err_code, rx_timeout};

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_q[$];
  logic [7:0] act_q[$];
  logic [1:0] cur_code = 2'b00;

  usb_rx_seq #(
    .SYNC_MIN_ZEROS(SYNC_MIN_ZEROS),
    .MAX_BITS      (MAX_BITS),
    .TIMEOUT_CYC   (TIMEOUT_CYC)
  ) dut (
    .clk           (clk),
    .rst_b         (rst_b),
    .rx_en         (rx_en),
    .line_bit      (line_bit),
    .line_se0      (line_se0),
    .bstr_out      (bstr_out),
    .bstr_out_avail(bstr_out_avail),
    .out_done      (out_done),
    .rx_busy       (rx_busy),
    .rx_err        (rx_err),
    .err_code      (err_code),
    .rx_timeout    (rx_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mk(input logic b, input logic av, input logic dn,
                                    input logic bz, input logic er, input logic [1:0] cd,
                                    input logic to);
    return {b, av, dn, bz, er, cd, to};
  endfunction

  // Expectation shorthands; err_code follows the bench's own record.
  function automatic logic [7:0] e_zero();
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cur_code, 1'b0);
  endfunction
  function automatic logic [7:0] e_busy();
    return mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, cur_code, 1'b0);
  endfunction
  function automatic logic [7:0] e_dat(input logic b);
    return mk(b, 1'b1, 1'b0, 1'b1, 1'b0, cur_code, 1'b0);
  endfunction
  function automatic logic [7:0] e_done();
    return mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, cur_code, 1'b0);
  endfunction
  function automatic logic [7:0] e_err();
    return mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, cur_code, 1'b0);
  endfunction

  task automatic step(input logic en, input logic se0, input logic b, input logic [7:0] e);
    rx_en    = en;
    line_se0 = se0;
    line_bit = b;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    act_q.push_back(obs);
  endtask

  // IDLE->HUNT entry, seven zeros, then the terminating 1.
  task automatic send_sync();
    step(1'b1, 1'b0, 1'b0, e_zero());
    repeat (7) step(1'b1, 1'b0, 1'b0, e_zero());
    step(1'b1, 1'b0, 1'b1, e_busy());
  endtask

  task automatic idle2();
    step(1'b0, 1'b0, 1'b0, e_zero());
    step(1'b0, 1'b0, 1'b0, e_zero());
  endtask

  task automatic test_reset();
    rst_b    = 1'b0;
    rx_en    = 1'b0;
    line_bit = 1'b0;
    line_se0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (obs !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_state got %b want %b", obs, 8'h00);
    end
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_good_packet();
    logic [7:0] pay = 8'hA5;
    logic [7:0] e, a, m;
    send_sync();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, pay[i], e_dat(pay[i]));
    step(1'b1, 1'b1, 1'b0, e_dat(1'b0));
    step(1'b1, 1'b1, 1'b0, e_dat(1'b0));
    step(1'b1, 1'b0, 1'b1, e_done());
    idle2();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      m = e[6] ? 8'hFF : 8'h7F;
      n_cmp++;
      if ((a & m) !== (e & m)) begin
        n_bad++;
        $display("FAIL good_packet step%0d got %b want %b", i, a & m, e & m);
      end
    end
  endtask

  task automatic test_stuffed_run();
    logic [7:0] bits = 8'b1011_1111; // sent LSB first: 1111110 1
    logic [7:0] e, a, m;
    send_sync();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, bits[i], e_dat(bits[i]));
    step(1'b1, 1'b1, 1'b0, e_dat(1'b0));
    step(1'b1, 1'b1, 1'b0, e_dat(1'b0));
    step(1'b1, 1'b0, 1'b1, e_done());
    idle2();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      m = e[6] ? 8'hFF : 8'h7F;
      n_cmp++;
      if ((a & m) !== (e & m)) begin
        n_bad++;
        $display("FAIL stuffed_run step%0d got %b want %b", i, a & m, e & m);
      end
    end
  endtask

  task automatic test_stuff_error();
    logic [7:0] e, a, m;
    send_sync();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, e_dat(1'b1));
    cur_code = 2'b01;
    step(1'b1, 1'b0, 1'b1, e_err());
    idle2();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      m = e[6] ? 8'hFF : 8'h7F;
      n_cmp++;
      if ((a & m) !== (e & m)) begin
        n_bad++;
        $display("FAIL stuff_error step%0d got %b want %b", i, a & m, e & m);
      end
    end
  endtask

  task automatic test_bad_eop();
    logic [3:0] bits = 4'b0101;
    logic [7:0] e, a, m;
    // SE0 then J
    send_sync();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, bits[i], e_dat(bits[i]));
    step(1'b1, 1'b1, 1'b0, e_dat(1'b0));
    cur_code = 2'b10;
    step(1'b1, 1'b0, 1'b1, e_err());
    idle2();
    // Three SE0
    cur_code = 2'b10;
    send_sync();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, bits[i], e_dat(bits[i]));
    step(1'b1, 1'b1, 1'b0, e_dat(1'b0));
    step(1'b1, 1'b1, 1'b0, e_dat(1'b0));
    step(1'b1, 1'b1, 1'b0, e_err());
    idle2();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      m = e[6] ? 8'hFF : 8'h7F;
      n_cmp++;
      if ((a & m) !== (e & m)) begin
        n_bad++;
        $display("FAIL bad_eop step%0d got %b want %b", i, a & m, e & m);
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] e, a, m;
    send_sync();
    for (int i = 0; i < MAX_BITS; i++) step(1'b1, 1'b0, 1'(i % 2), e_dat(1'(i % 2)));
    cur_code = 2'b11;
    step(1'b1, 1'b0, 1'b0, e_err());
    idle2();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      m = e[6] ? 8'hFF : 8'h7F;
      n_cmp++;
      if ((a & m) !== (e & m)) begin
        n_bad++;
        $display("FAIL overflow step%0d got %b want %b", i, a & m, e & m);
      end
    end
  endtask

  task automatic test_timeout();
    logic [7:0] e, a, m;
    step(1'b1, 1'b0, 1'b0, e_zero()); // IDLE -> HUNT
    for (int i = 0; i < TIMEOUT_CYC; i++) begin
      e = e_zero();
      if (i == TIMEOUT_CYC - 1) e[0] = 1'b1;
      step(1'b1, 1'b0, 1'((i % 4) == 3), e);
    end
    idle2();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      m = e[6] ? 8'hFF : 8'h7F;
      n_cmp++;
      if ((a & m) !== (e & m)) begin
        n_bad++;
        $display("FAIL timeout step%0d got %b want %b", i, a & m, e & m);
      end
    end
  endtask

  task automatic test_abort();
    logic [7:0] e, a, m;
    // Mid-DATA
    send_sync();
    step(1'b1, 1'b0, 1'b1, e_dat(1'b1));
    step(1'b1, 1'b0, 1'b0, e_dat(1'b0));
    step(1'b1, 1'b0, 1'b1, e_dat(1'b1));
    step(1'b0, 1'b0, 1'b1, e_zero());
    step(1'b0, 1'b0, 1'b0, e_zero());
    // Abort coincident with a would-be stuff error
    send_sync();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, e_dat(1'b1));
    step(1'b0, 1'b0, 1'b1, e_zero());
    idle2();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      m = e[6] ? 8'hFF : 8'h7F;
      n_cmp++;
      if ((a & m) !== (e & m)) begin
        n_bad++;
        $display("FAIL abort step%0d got %b want %b", i, a & m, e & m);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e, a, m;
    send_sync();
    step(1'b1, 1'b0, 1'b0, e_dat(1'b0));
    step(1'b1, 1'b0, 1'b1, e_dat(1'b1));
    step(1'b1, 1'b1, 1'b0, e_dat(1'b0));
    step(1'b1, 1'b1, 1'b0, e_dat(1'b0));
    step(1'b1, 1'b0, 1'b1, e_done());
    step(1'b1, 1'b0, 1'b0, e_zero()); // DONE -> IDLE with rx_en held
    send_sync();
    step(1'b1, 1'b0, 1'b1, e_dat(1'b1));
    step(1'b1, 1'b1, 1'b0, e_dat(1'b0));
    step(1'b1, 1'b1, 1'b0, e_dat(1'b0));
    step(1'b1, 1'b0, 1'b1, e_done());
    idle2();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      m = e[6] ? 8'hFF : 8'h7F;
      n_cmp++;
      if ((a & m) !== (e & m)) begin
        n_bad++;
        $display("FAIL back_to_back step%0d got %b want %b", i, a & m, e & m);
      end
    end
  endtask

  task automatic test_reset_mid_eop();
    logic [7:0] e, a, m;
    send_sync();
    step(1'b1, 1'b0, 1'b1, e_dat(1'b1));
    step(1'b1, 1'b0, 1'b0, e_dat(1'b0));
    step(1'b1, 1'b1, 1'b0, e_dat(1'b0)); // now in EOP1
    #2;
    rst_b = 1'b0;
    #1;
    n_cmp++;
    if (obs !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_mid_eop1 got %b want %b", obs, 8'h00);
    end
    rx_en = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    cur_code = 2'b00;
    step(1'b0, 1'b0, 1'b0, e_zero());
    step(1'b1, 1'b1, 1'b0, e_zero()); // IDLE -> HUNT, SE0 ignored
    step(1'b0, 1'b0, 1'b0, e_zero());
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      m = e[6] ? 8'hFF : 8'h7F;
      n_cmp++;
      if ((a & m) !== (e & m)) begin
        n_bad++;
        $display("FAIL reset_mid_eop step%0d got %b want %b", i, a & m, e & m);
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_packet();
    test_stuffed_run();
    test_stuff_error();
    test_bad_eop();
    test_overflow();
    test_timeout();
    test_abort();
    test_back_to_back();
    test_reset_mid_eop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
